// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the UART instruction-memory loader.
// Frame layout: MAGIC, LEN_LO, LEN_HI, N*BYTES little-endian data bytes, XOR checksum.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } loader_state_t;

  localparam logic [7:0]  LOADER_MAGIC = 8'hA5;
  localparam int unsigned LEN_W        = 16;
  localparam int unsigned BYTE_W       = 8;
  localparam logic [7:0]  CSUM_SEED    = 8'h00;

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

  // States in which the inter-byte idle timer is armed.
  function automatic logic in_frame(input loader_state_t s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Packs a stream of bytes into little-endian words; the completed word is presented
// combinationally with the last byte so the caller can register it on the same edge.
module imem_word_assembler
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clr,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte,
  output logic                  o_word_valid,
  output logic [DATA_WIDTH-1:0] o_word
);

  localparam int BYTES  = DATA_WIDTH / BYTE_W;
  localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES - 1);

  logic [LANE_W-1:0]     r_lane;
  logic [DATA_WIDTH-1:0] r_lanes;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_word;

  // Merge the incoming byte into its lane of the partially built word.
  always_comb begin
    w_last = (r_lane == LAST_LANE);
    w_word = r_lanes;
    for (int i = 0; i < BYTES; i++) begin
      if (LANE_W'(i) == r_lane) begin
        w_word[i*8 +: 8] = i_byte;
      end else begin
        w_word[i*8 +: 8] = r_lanes[i*8 +: 8];
      end
    end
  end

  assign o_word_valid = i_byte_valid & w_last;
  assign o_word       = w_word;

  // Lane counter and lane storage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lane  <= '0;
      r_lanes <= '0;
    end else if (i_clr) begin
      r_lane  <= '0;
      r_lanes <= '0;
    end else if (i_byte_valid) begin
      r_lanes <= w_word;
      r_lane  <= w_last ? '0 : (r_lane + LANE_W'(1));
    end else begin
      r_lane  <= r_lane;
      r_lanes <= r_lanes;
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// Receives a framed program image from the UART and writes it into instruction RAM,
// holding the core in reset until a frame with a matching checksum has been stored.
module imem_uart_loader
  import imem_loader_pkg::*;
#(
  parameter int         DATA_WIDTH    = 32,
  parameter int         ADDR_WIDTH    = 10,
  parameter logic [7:0] MAGIC         = LOADER_MAGIC,
  parameter int         IDLE_TIMEOUT  = 100000,
  parameter bit         HOLD_AT_RESET = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx_valid,
  input  logic [7:0]            i_rx_data,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wd,
  output logic                  o_cpu_hold,
  output logic                  o_load_done,
  output logic                  o_load_err
);

  localparam int IDX_W = ADDR_WIDTH + 1;
  localparam int TMO_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(IDLE_TIMEOUT - 1);

  typedef logic [LEN_W:0] len_ext_t;
  localparam len_ext_t LEN_ONE   = {{LEN_W{1'b0}}, 1'b1};
  localparam len_ext_t MAX_WORDS = LEN_ONE << ADDR_WIDTH;

  loader_state_t         r_state;
  logic [LEN_W-1:0]      r_len;
  logic [IDX_W-1:0]      r_widx;
  logic [7:0]            r_csum;
  logic [TMO_W-1:0]      r_tmo;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wd;
  logic                  r_cpu_hold;
  logic                  r_load_done;
  logic                  r_load_err;

  logic                  w_in_frame;
  logic                  w_start;
  logic                  w_asm_valid;
  logic                  w_word_valid;
  logic [DATA_WIDTH-1:0] w_word;
  len_ext_t              w_len_full;
  logic [IDX_W-1:0]      w_widx_next;
  logic                  w_last_word;
  logic                  w_tmo_expire;

  // Frame-level decode shared by the FSM.
  always_comb begin
    w_in_frame   = in_frame(r_state);
    w_start      = i_rx_valid && (i_rx_data == MAGIC) && !w_in_frame;
    w_asm_valid  = i_rx_valid && (r_state == ST_DATA);
    w_len_full   = {1'b0, i_rx_data, r_len[7:0]};
    w_widx_next  = r_widx + IDX_W'(1);
    w_last_word  = (len_ext_t'(w_widx_next) == {1'b0, r_len});
    w_tmo_expire = !i_rx_valid && (r_tmo == TMO_LAST);
  end

  imem_word_assembler #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_asm (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clr        (w_start),
    .i_byte_valid (w_asm_valid),
    .i_byte       (i_rx_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // Loader FSM with checksum, idle timer and registered memory port.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_widx      <= '0;
      r_csum      <= CSUM_SEED;
      r_tmo       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wd    <= '0;
      r_cpu_hold  <= HOLD_AT_RESET;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;

      if (w_in_frame) begin
        if (i_rx_valid) begin
          r_tmo <= '0;
        end else if (w_tmo_expire) begin
          r_tmo      <= '0;
          r_state    <= ST_ERROR;
          r_load_err <= 1'b1;
          r_cpu_hold <= 1'b1;
        end else begin
          r_tmo <= r_tmo + TMO_W'(1);
        end
      end else begin
        r_tmo <= '0;
      end

      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (w_start) begin
            r_state     <= ST_LEN_LO;
            r_cpu_hold  <= 1'b1;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
            r_widx      <= '0;
            r_csum      <= CSUM_SEED;
          end
        end
        ST_LEN_LO: begin
          if (i_rx_valid) begin
            r_len[7:0] <= i_rx_data;
            r_state    <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (i_rx_valid) begin
            r_len[15:8] <= i_rx_data;
            if (w_len_full > MAX_WORDS) begin
              r_state    <= ST_ERROR;
              r_load_err <= 1'b1;
              r_cpu_hold <= 1'b1;
            end else if (w_len_full == '0) begin
              r_state <= ST_CSUM;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (i_rx_valid) begin
            r_csum <= csum_step(r_csum, i_rx_data);
            if (w_word_valid) begin
              r_mem_we   <= 1'b1;
              r_mem_addr <= r_widx[ADDR_WIDTH-1:0];
              r_mem_wd   <= w_word;
              r_widx     <= w_widx_next;
              if (w_last_word) begin
                r_state <= ST_CSUM;
              end
            end
          end
        end
        ST_CSUM: begin
          if (i_rx_valid) begin
            if (i_rx_data == r_csum) begin
              r_state     <= ST_DONE;
              r_load_done <= 1'b1;
              r_cpu_hold  <= 1'b0;
            end else begin
              r_state    <= ST_ERROR;
              r_load_err <= 1'b1;
              r_cpu_hold <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wd    = r_mem_wd;
  assign o_cpu_hold  = r_cpu_hold;
  assign o_load_done = r_load_done;
  assign o_load_err  = r_load_err;

endmodule
